// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - bin over WIDTH bits, DIGIT bits per clock,
// with a registered borrow chain and valid/ready handshakes on both sides.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);

   localparam int unsigned STEPS = WIDTH / DIGIT;
   localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             brw_q, brw_d;
   logic             bo_q, bo_d;
   logic             zero_q, zero_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DIGIT:0]   slice;
   logic             last;

   always_comb begin
      // One DIGIT-wide slice, computed one bit wider so the top bit is the borrow
      slice = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
      last  = (count_q == CW'(STEPS - 1));

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      bo_d    = bo_q;
      zero_d  = zero_q;
      count_d = count_q;

      case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               acc_d   = '0;
               count_d = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            brw_d = slice[DIGIT];
            acc_d = (acc_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
            if (last) begin
               // Publish into the output registers so results hold while the next op runs
               count_d = '0;
               diff_d  = acc_d;
               bo_d    = slice[DIGIT];
               zero_d  = (acc_d == '0);
               state_d = StDone;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         bo_q    <= 1'b0;
         zero_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         bo_q    <= bo_d;
         zero_q  <= zero_d;
         count_q <= count_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign diff       = diff_q;
   assign borrow_out = bo_q;
   assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor in 8x1 and 16x4 configurations.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        in_valid8 = 1'b0, bin8 = 1'b0, out_ready8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        in_ready8, out_valid8, bo8, zero8;
   logic [7:0]  diff8;

   logic        in_valid16 = 1'b0, bin16 = 1'b0, out_ready16 = 1'b1;
   logic [15:0] a16 = '0, b16 = '0;
   logic        in_ready16, out_valid16, bo16, zero16;
   logic [15:0] diff16;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid8),
      .in_ready   (in_ready8),
      .a          (a8),
      .b          (b8),
      .bin        (bin8),
      .out_valid  (out_valid8),
      .out_ready  (out_ready8),
      .diff       (diff8),
      .borrow_out (bo8),
      .zero       (zero8)
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid16),
      .in_ready   (in_ready16),
      .a          (a16),
      .b          (b16),
      .bin        (bin16),
      .out_valid  (out_valid16),
      .out_ready  (out_ready16),
      .diff       (diff16),
      .borrow_out (bo16),
      .zero       (zero16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one 8-bit op and leaves the DUT in DONE with out_ready low.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb, input logic ez, input bit poke);
      int lat;
      @(negedge clk);
      check({tag, ".in_ready"}, 32'(in_ready8), 32'd1);
      a8 = a; b8 = b; bin8 = bin; in_valid8 = 1'b1;
      @(negedge clk);
      // Scramble inputs after the accept edge: only the accepted values may matter
      in_valid8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bin;
      lat = 0;
      while (!out_valid8 && lat < 40) begin
         @(negedge clk);
         lat++;
         if (poke && lat == 2) begin
            in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
         end else begin
            in_valid8 = 1'b0;
         end
      end
      in_valid8 = 1'b0;
      check({tag, ".latency"}, 32'(lat), 32'd8);
      check({tag, ".diff"}, 32'(diff8), 32'(ed));
      check({tag, ".borrow"}, 32'(bo8), 32'(eb));
      check({tag, ".zero"}, 32'(zero8), 32'(ez));
   endtask

   task automatic rel8(input string tag);
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      check({tag, ".rel_out_valid"}, 32'(out_valid8), 32'd0);
      check({tag, ".rel_in_ready"}, 32'(in_ready8), 32'd1);
   endtask

   // 16-bit op with out_ready held high; expected values come from the caller.
   task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic [15:0] ed, input logic eb);
      int lat;
      @(negedge clk);
      check({tag, ".in_ready"}, 32'(in_ready16), 32'd1);
      a16 = a; b16 = b; bin16 = bin; in_valid16 = 1'b1;
      @(negedge clk);
      in_valid16 = 1'b0; a16 = ~a; b16 = ~b; bin16 = ~bin;
      lat = 0;
      while (!out_valid16 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'd4);
      check({tag, ".diff"}, 32'(diff16), 32'(ed));
      check({tag, ".borrow"}, 32'(bo16), 32'(eb));
      check({tag, ".zero"}, 32'(zero16), 32'(ed == 16'h0000));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] ra, rb, ed;
      logic        rbin, eb;
      logic [7:0]  held;

      #2;
      check("rst.in_ready8", 32'(in_ready8), 32'd1);
      check("rst.out_valid8", 32'(out_valid8), 32'd0);
      check("rst.diff8", 32'(diff8), 32'd0);
      check("rst.borrow8", 32'(bo8), 32'd0);
      check("rst.zero8", 32'(zero8), 32'd0);
      check("rst.in_ready16", 32'(in_ready16), 32'd1);
      check("rst.out_valid16", 32'(out_valid16), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op8("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      rel8("t1");
      op8("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
      rel8("t2a");
      op8("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      rel8("t2b");
      op8("t3", 8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      rel8("t3");
      check("t3.still_idle", 32'(in_ready8), 32'd1);

      op8("t4", 8'h5A, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);
      held = diff8;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("t4.hold%0d.out_valid", i), 32'(out_valid8), 32'd1);
         check($sformatf("t4.hold%0d.in_ready", i), 32'(in_ready8), 32'd0);
         check($sformatf("t4.hold%0d.diff", i), 32'(diff8), 32'h4B);
      end
      rel8("t4");
      check("t4.held_diff", 32'(held), 32'h4B);

      @(negedge clk);
      a8 = 8'h37; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5.out_valid", 32'(out_valid8), 32'd0);
      check("t5.in_ready", 32'(in_ready8), 32'd1);
      check("t5.diff", 32'(diff8), 32'd0);
      check("t5.borrow", 32'(bo8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op8("t5b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
      rel8("t5b");

      op16("t6", 16'h1234, 16'h4321, 1'b0, 16'hCF13, 1'b1);
      op16("t6z", 16'hABCD, 16'hABCC, 1'b1, 16'h0000, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rbin = 1'($urandom);
         {eb, ed} = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
         op16($sformatf("rnd%0d", i), ra, rb, rbin, ed, eb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
